intra4_edge_buf: RTL
====================

// Module: intra4_edge_buf
// PURPOSE
//  Supplies the top / top_right neighbour rows to the 4x4 intra predictors
//  (LD4, VL4, etc.) and captures each reconstructed 4x4 block's bottom row
//  as the above-edge for the next block row.
//  Walks the frame in raster order of 4x4 blocks. Holds one frame-width
//  line of bottom rows in a synchronous RAM.
// PARAMETERS
//  BIT_WIDTH   8    bits per pixel
//  BLOCK_SIZE  4    block edge in pixels; edge row = BIT_WIDTH*BLOCK_SIZE bits
//  MAX_BLKS_W  480  max frame width in 4x4 blocks (RAM depth)
//  ADDR_W      9    RAM address / block-x counter width, >= clog2(MAX_BLKS_W)
//  CNT_W       10   block-y counter and height_blks width
// PORTS
//  clk          in   1        clock, all logic rising-edge
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        frame start pulse, sampled only in IDLE
//  width_blks   in   ADDR_W   frame width in blocks, latched on start
//  height_blks  in   CNT_W    frame height in blocks, latched on start
//  busy         out  1        high from start accept until done
//  done         out  1        one-cycle pulse after the last block is written
//  out_valid    out  1        top/top_right valid for the current block
//  out_ready    in   1        predictor accepts the edges
//  top          out  32       above row, pixel 0 in [7:0]
//  top_right    out  32       above-right row, pixel 0 in [7:0]
//  blk_x        out  ADDR_W   current block column
//  blk_y        out  CNT_W    current block row
//  in_valid     in   1        reconstructed block present
//  in_ready     out  1        block accepted when in_valid & in_ready
//  in_data      in   128      reconstructed 4x4, dst layout; bottom row = [127:96]
// BEHAVIOUR
//  Reset: FSM=IDLE; busy, done, out_valid and in_ready = 0;
//   top, top_right, blk_x and blk_y = 0. RAM contents are not reset.
//  start with width_blks==0, height_blks==0 or width_blks>MAX_BLKS_W:
//   ignored, and done is not pulsed.
//  start while busy: ignored.
//  FSM states: IDLE -> RD0 -> RD1 -> RD2 -> PRESENT -> WAIT_RECON -> WRITE.
//  IDLE: on a valid start, latch the sizes, set x=0 and y=0, go to RD0.
//  RD0: issue RAM read at address x.
//  RD1: capture RAM data into the top register; issue read at x+1.
//   When x==width-1, the read is suppressed.
//  RD2: capture the x+1 data into the top_right register.
//  PRESENT: out_valid=1. out_valid, top, top_right, blk_x and blk_y are held
//   stable until out_ready. Then out_valid=0 next cycle, go to WAIT_RECON.
//  out_valid rises exactly 3 cycles after the start / WRITE cycle.
//  WAIT_RECON: in_ready=1. On in_valid, register in_data[127:96] and go to WRITE.
//  WRITE: write the bottom row to RAM[x]. Then advance:
//   if x<width-1: x++ and go to RD0;
//   else x=0, y++; if y was height-1, pulse done, drop busy, go to IDLE.
//  Edge rules, applied as muxes at capture:
//   y==0: top = top_right = {4{8'd127}}; RAM data is ignored.
//   y>0 and x==width-1: top_right = {4{top[31:24]}}.
//   width==1: every block uses the right-edge rule.
//  Ordering: RAM[x+1] still holds row y-1 when block x is read, because
//   writes are strictly raster order. No bypass path is required.
//  Reset asserted mid-operation: immediate return to IDLE; the current
//   block is abandoned and done is not pulsed.
// TESTING
//  Reset -> busy, done, out_valid, in_ready, top, top_right all 0;
//   start asserted while reset is high has no effect.
//  start with w=2, h=2 -> out_valid 3 cycles later, top=0x7F7F7F7F,
//   top_right=0x7F7F7F7F, blk_x=0, blk_y=0.
//  Row 0 bottom rows 0x04030201 (x0) and 0x08070605 (x1) ->
//   row1 x0: top=0x04030201, top_right=0x08070605;
//   row1 x1: top=0x08070605, top_right=0x08080808.
//  out_ready low for 5 cycles in PRESENT -> out_valid and all outputs
//   stable; in_ready stays 0 until the out handshake.
//  Last block written -> done pulses once, busy=0 the same cycle;
//   a 2nd start yields 0x7F edges again and ignores stale RAM.
//  rst pulsed in WAIT_RECON; then start w=1, h=2 -> restarts at (0,0) with no done;
//   row1 top_right = {4{top[31:24]}}.

Source files
------------

// File: rtl/intra4_edge_buf.sv
// Above / above-right edge supplier for 4x4 intra prediction. Walks the frame in
// raster block order and keeps one line of block bottom rows in a block RAM.
module intra4_edge_buf #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int MAX_BLKS_W = 480,
  parameter int ADDR_W     = 9,
  parameter int CNT_W      = 10
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [ADDR_W-1:0]                       width_blks,
  input  logic [CNT_W-1:0]                        height_blks,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [BIT_WIDTH*BLOCK_SIZE-1:0]         top,
  output logic [BIT_WIDTH*BLOCK_SIZE-1:0]         top_right,
  output logic [ADDR_W-1:0]                       blk_x,
  output logic [CNT_W-1:0]                        blk_y,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [BIT_WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] in_data
);

  localparam int EDGE_W = BIT_WIDTH * BLOCK_SIZE;
  localparam int BLK_W  = EDGE_W * BLOCK_SIZE;
  localparam logic [ADDR_W:0] MAX_W = (ADDR_W+1)'(MAX_BLKS_W);

  typedef enum logic [2:0] {
    IDLE, RD0, RD1, RD2, PRESENT, WAIT_RECON, WRITE
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   width_reg;
  logic [CNT_W-1:0]    height_reg;
  logic [ADDR_W-1:0]   x_reg;
  logic [CNT_W-1:0]    y_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                out_valid_reg;
  logic                in_ready_reg;
  logic [EDGE_W-1:0]   top_reg;
  logic [EDGE_W-1:0]   top_right_reg;
  logic [EDGE_W-1:0]   bottom_reg;

  logic [EDGE_W-1:0]   mem [MAX_BLKS_W];
  logic [EDGE_W-1:0]   rd_data_reg;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic                wr_en;

  logic                start_ok;
  logic                x_last;
  logic                y_last;
  logic [EDGE_W-1:0]   y0_fill;
  logic [EDGE_W-1:0]   right_fill;

  // Only the bottom pixel row of the reconstructed block is stored.
  logic                unused_rows;
  assign unused_rows = ^in_data[BLK_W-EDGE_W-1:0];

  // Row 0 has no neighbour above: mid-grey. Right column repeats top's last pixel.
  generate
    for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_fill
      assign y0_fill[gi*BIT_WIDTH +: BIT_WIDTH]    = BIT_WIDTH'(127);
      assign right_fill[gi*BIT_WIDTH +: BIT_WIDTH] = top_reg[EDGE_W-1 -: BIT_WIDTH];
    end
  endgenerate

  assign start_ok = (width_blks != '0) && (height_blks != '0) &&
                    ({1'b0, width_blks} <= MAX_W);
  assign x_last   = (x_reg == width_reg - ADDR_W'(1));
  assign y_last   = (y_reg == height_reg - CNT_W'(1));

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = x_reg;
    wr_en   = (state_reg == WRITE);
    if (state_reg == RD0) begin
      rd_en = 1'b1;
    end else if (state_reg == RD1 && !x_last) begin
      rd_en   = 1'b1;
      rd_addr = x_reg + ADDR_W'(1);
    end
  end

  // Line RAM: registered read, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[x_reg] <= bottom_reg;
    if (rd_en)
      rd_data_reg <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      width_reg     <= '0;
      height_reg    <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
      top_reg       <= '0;
      top_right_reg <= '0;
      bottom_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && start_ok) begin
            width_reg  <= width_blks;
            height_reg <= height_blks;
            x_reg      <= '0;
            y_reg      <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= RD0;
          end
        end
        RD0: state_reg <= RD1;
        RD1: begin
          top_reg   <= (y_reg == '0) ? y0_fill : rd_data_reg;
          state_reg <= RD2;
        end
        RD2: begin
          if (y_reg == '0)
            top_right_reg <= y0_fill;
          else if (x_last)
            top_right_reg <= right_fill;
          else
            top_right_reg <= rd_data_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= WAIT_RECON;
          end
        end
        WAIT_RECON: begin
          if (in_valid) begin
            bottom_reg   <= in_data[BLK_W-1 -: EDGE_W];
            in_ready_reg <= 1'b0;
            state_reg    <= WRITE;
          end
        end
        WRITE: begin
          if (!x_last) begin
            x_reg     <= x_reg + ADDR_W'(1);
            state_reg <= RD0;
          end else begin
            x_reg <= '0;
            y_reg <= y_reg + CNT_W'(1);
            if (y_last) begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              state_reg <= RD0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign out_valid = out_valid_reg;
  assign in_ready  = in_ready_reg;
  assign top       = top_reg;
  assign top_right = top_right_reg;
  assign blk_x     = x_reg;
  assign blk_y     = y_reg;

endmodule
